// File: rtl/hex_scan_pkg.sv
// hex_scan_pkg: shared state encoding and parameter defaults for the hex scan driver
package hex_scan_pkg;
  localparam int DIGITS_DEF = 4;
  localparam int DWELL_DEF = 1024;
  typedef enum logic {IDLE, SCAN} state_e;
endpackage

// File: rtl/hex_scan_driver_if.sv
// hex_scan_driver_if: load handshake and display outputs of the hex scan driver
interface hex_scan_driver_if
  import hex_scan_pkg::*;
#(parameter int DIGITS = DIGITS_DEF);
  logic load_valid;
  logic load_ready;
  logic [4*DIGITS-1:0] load_data;
  logic stop;
  logic [3:0] nibble;
  logic [DIGITS-1:0] digit_sel;
  logic frame_tick;
  logic active;
  modport master (output load_valid, load_data, stop, input load_ready, nibble, digit_sel, frame_tick, active);
  modport slave (input load_valid, load_data, stop, output load_ready, nibble, digit_sel, frame_tick, active);
endinterface

// File: rtl/hex_scan_timer.sv
// hex_scan_timer: dwell counter, done high on the last cycle of every DWELL-cycle period
module hex_scan_timer
  import hex_scan_pkg::*;
#(parameter int DWELL = DWELL_DEF)
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic done
);
  localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign done = cnt_q == CW'(DWELL - 1);
  assign cnt_d = (clear || done) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/hex_scan_driver.sv
// hex_scan_driver: multiplexed hex display scanner with double-buffered load.
// Define HEX_SCAN_BLANK_LEADING_ZEROS_EN to blank digits above the most significant nonzero one.
module hex_scan_driver
  import hex_scan_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int DWELL = DWELL_DEF
)
(
  input logic clk,
  input logic rst,
  hex_scan_driver_if.slave bus
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int DW = 4 * DIGITS;
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] act_q, act_d, shd_q, shd_d;
  logic pend_q, pend_d, tick_q, tick_d;
  logic [3:0] nib_q, nib_d;
  logic [DIGITS-1:0] sel_q, sel_d, show;
  logic done, xfer, wrap;
`ifdef HEX_SCAN_BLANK_LEADING_ZEROS_EN
  logic [DIGITS:0] nz;
`endif
  hex_scan_timer #(.DWELL(DWELL)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (state_q == IDLE || bus.stop),
    .done  (done)
  );
  assign bus.load_ready = !pend_q && !bus.stop && !rst;
  assign xfer = bus.load_valid && bus.load_ready;
  assign wrap = state_q == SCAN && done && idx_q == IW'(DIGITS - 1);
  assign bus.nibble = nib_q;
  assign bus.digit_sel = sel_q;
  assign bus.frame_tick = tick_q;
  assign bus.active = state_q == SCAN;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    act_d = act_q;
    shd_d = shd_q;
    pend_d = pend_q;
    tick_d = 1'b0;
    if (bus.stop) begin
      state_d = IDLE;
      idx_d = '0;
      pend_d = 1'b0;
    end else if (state_q == IDLE) begin
      if (xfer) begin
        state_d = SCAN;
        act_d = bus.load_data;
      end
    end else begin
      if (done) idx_d = wrap ? '0 : idx_q + 1'b1;
      tick_d = wrap;
      if (wrap && pend_q) begin
        act_d = shd_q;
        pend_d = 1'b0;
      end
      // a load on the wrap edge only fills the shadow; it shows one frame later
      if (xfer) begin
        shd_d = bus.load_data;
        pend_d = 1'b1;
      end
    end
`ifdef HEX_SCAN_BLANK_LEADING_ZEROS_EN
    nz[DIGITS] = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) nz[k] = nz[k+1] || (|act_d[4*k +: 4]);
    show = nz[DIGITS-1:0] | DIGITS'(1);
`else
    show = '1;
`endif
    nib_d = state_d == SCAN ? act_d[4*idx_d +: 4] : 4'h0;
    sel_d = state_d == SCAN ? (DIGITS'(1) << idx_d) & show : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      act_q <= '0;
      shd_q <= '0;
      pend_q <= 1'b0;
      tick_q <= 1'b0;
      nib_q <= '0;
      sel_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      act_q <= act_d;
      shd_q <= shd_d;
      pend_q <= pend_d;
      tick_q <= tick_d;
      nib_q <= nib_d;
      sel_q <= sel_d;
    end
  end
endmodule

// File: doc/hex_scan_driver.md
HEX_SCAN_DRIVER -- requirements
Module: hex_scan_driver

Interface
REQ-001 SHALL have parameter DIGITS, default 4, giving the number of multiplexed hex digits (range 1..8).
REQ-002 SHALL have parameter DWELL, default 1024, giving the clock cycles each digit stays selected (range 1..65535).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port load_valid, input, 1 bit: load_data is offered.
REQ-006 SHALL have port load_ready, output, 1 bit: the block accepts load_data this cycle.
REQ-007 SHALL have port load_data, input, 4*DIGITS bits: packed hex value; digit k is bits [4k+3:4k].
REQ-008 SHALL have port stop, input, 1 bit: return to idle and blank the display.
REQ-009 SHALL have port nibble, output, 4 bits: code of the selected digit; bit 3 drives in1 and bit 0 drives in4 of the downstream segment decoders.
REQ-010 SHALL have port digit_sel, output, DIGITS bits: one-hot active-high digit enable.
REQ-011 SHALL have port frame_tick, output, 1 bit: one-cycle pulse at each frame wrap.
REQ-012 SHALL have port active, output, 1 bit: the block is in SCAN.

Function
REQ-013 SHALL implement two states: IDLE (digit_sel=0, nibble=0, active=0) and SCAN (active=1).
REQ-014 SHALL complete a transfer in any cycle where load_valid && load_ready.
REQ-015 SHALL drive load_ready = !pending && !stop && !rst, combinationally.
REQ-016 SHALL, on a transfer in IDLE at cycle N, write the data to the active register and enter SCAN; from cycle N+1, digit 0 SHALL be selected with a zeroed dwell count.
REQ-017 SHALL, on a transfer in SCAN, write the data to the shadow register and set pending; the current frame continues unchanged.
REQ-018 SHALL, in SCAN, hold each digit for exactly DWELL cycles, then advance k -> k+1, wrapping from DIGITS-1 to 0.
REQ-019 SHALL, at the wrap from DIGITS-1 to 0, pulse frame_tick for the first cycle of digit 0; if pending is set, SHALL copy the shadow register to the active register and clear pending in that same edge, with the new value shown from digit 0.
REQ-020 SHALL, when a transfer and a wrap occur on the same edge with pending clear, put the new data in the shadow register only; it becomes visible at the next wrap.
REQ-021 SHALL register nibble and digit_sel, with nibble always equal to the active-register digit whose digit_sel bit is set.
REQ-022 SHALL, when stop is high, go to IDLE on the next edge, clear pending and the dwell count, and accept no transfer in that cycle.
REQ-023 SHALL, with DIGITS=1, hold digit_sel=1 and pulse frame_tick every DWELL cycles.
REQ-024 SHALL size the dwell counter to max(1, clog2(DWELL)) bits and never let it exceed DWELL-1.

Reset
REQ-025 SHALL, while rst is high, force IDLE, pending=0, dwell count=0, digit index=0, both data registers=0, nibble=0, digit_sel=0, frame_tick=0 and active=0; load_ready SHALL be 0.
REQ-026 SHALL, on rst asserted mid-frame, discard all state at the next edge, with no frame_tick.

Configuration
REQ-027 SHALL, with macro HEX_SCAN_BLANK_LEADING_ZEROS_EN defined, force digit_sel to 0 for any digit above the most significant nonzero digit of the active register; digit 0 is always shown and the dwell timing is unchanged.
REQ-028 SHALL, without HEX_SCAN_BLANK_LEADING_ZEROS_EN, show every digit.

Structure
REQ-029 SHALL place the state enum (IDLE, SCAN) and the DIGITS/DWELL defaults in shared package hex_scan_pkg.
REQ-030 SHALL implement the dwell counter as sub-module hex_scan_timer, with inputs clk, rst and clear, and output done pulsing every DWELL cycles.

Verification (DIGITS=4, DWELL=4)
REQ-031 SHALL check: after reset, load 16'h1A3F at cycle 10 -> from cycle 11 nibble is F, 3, A, 1 for 4 cycles each, digit_sel is 0001, 0010, 0100, 1000, and frame_tick pulses at cycle 27.
REQ-032 SHALL check: in SCAN, load 16'h0042 mid-frame -> load_ready=0 until the wrap, the old value completes its frame, and 0042 appears from digit 0 at the wrap.
REQ-033 SHALL check: a transfer on the wrap edge -> value appears one frame later, and load_ready is low in between.
REQ-034 SHALL check: stop asserted mid-digit 2 together with load_valid -> no transfer, IDLE next cycle, digit_sel=0, pending cleared.
REQ-035 SHALL check: rst asserted mid-frame with pending set -> all outputs 0 next cycle; load_ready is 0 during rst and 1 the cycle after.
REQ-036 SHALL check: with HEX_SCAN_BLANK_LEADING_ZEROS_EN, load 16'h0042 -> digit_sel is 0001, 0010, 0000, 0000 per dwell; load 16'h0000 -> only digit 0 is shown.
